// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample ratio and the
// baud divisor table used by both the transmitter and the receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

    // Clock cycles per oversample tick at 100 MHz: 9600, 19200, 38400, 115200 baud.
    function automatic logic [DIV_W-1:0] baud_div(input logic [1:0] baud_sel);
        case (baud_sel)
            2'd0:    return 10'd651;
            2'd1:    return 10'd326;
            2'd2:    return 10'd163;
            default: return 10'd54;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every baud_div(baud_sel) clocks,
// with a synchronous clear so ticks can be re-phased to a start edge.
module uart_rx_tick_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] baud_sel,
    output logic       tick
);
    import uart_pkg::*;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1;

    assign div_m1 = baud_div(baud_sel) - DIV_W'(1);
    assign tick   = (cnt == div_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (clr || tick)  cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: 16x oversampling, 3-sample majority vote, 8N1/8E1/8O1 framing,
// one-entry valid/ready holding register with parity, framing and overrun flags.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           baud_sel,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_bussy,
    output logic                 rx_tick,
    output logic                 rx_error,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    import uart_pkg::*;

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    // Vote window is the three samples around mid-bit (7/8/9 at 16x).
    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    uart_rx_state_e state, next;

    logic                 sync1, sync2, line_q;
    logic                 fall, start_det, mid_tick, end_tick, maj;
    logic                 complete, frame_err;
    logic [SW-1:0]        samp;
    logic                 v_a, v_b;
    logic [1:0]           baud_q;
    logic                 pen_q, podd_q, perr_q;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= rx_serial;
            sync2  <= sync1;
            line_q <= sync2;
        end
    end

    assign fall      = line_q & ~sync2;
    assign start_det = (state == IDLE) && fall;
    assign mid_tick  = rx_tick && (samp == S_MID);
    assign end_tick  = rx_tick && (samp == S_LAST);
    assign maj       = (v_a & v_b) | (v_a & sync2) | (v_b & sync2);
    assign rx_bussy  = (state != IDLE);

    uart_rx_tick_gen u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_det),
        .baud_sel (baud_q),
        .tick     (rx_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next      = state;
        complete  = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            IDLE:   if (fall) next = START;
            START: begin
                if (mid_tick && maj) next = IDLE;
                else if (end_tick)   next = DATA;
            end
            DATA:   if (end_tick && bit_cnt == BW'(DATA_BITS)) next = pen_q ? PARITY : STOP;
            PARITY: if (end_tick) next = STOP;
            STOP: begin
                if (mid_tick) begin
                    if (maj) begin
                        next     = IDLE;
                        complete = 1'b1;
                    end else begin
                        next      = BREAK;
                        frame_err = 1'b1;
                    end
                end
            end
            BREAK:  if (sync2) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Sample index, vote samples and per-frame configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp    <= '0;
            v_a     <= 1'b1;
            v_b     <= 1'b1;
            baud_q  <= 2'd0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            perr_q  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start_det) begin
            samp    <= '0;
            baud_q  <= baud_sel;
            pen_q   <= parity_en;
            podd_q  <= parity_odd;
            perr_q  <= 1'b0;
            bit_cnt <= '0;
        end else if (rx_tick) begin
            samp <= samp + 1'b1;
            if (samp == S_A) v_a <= sync2;
            if (samp == S_B) v_b <= sync2;
            if (mid_tick && state == DATA) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (mid_tick && state == PARITY) perr_q <= maj ^ (^shreg) ^ podd_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_error      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_error   <= frame_err;
            rx_overrun <= 1'b0;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_byte       <= shreg;
                    rx_parity_err <= perr_q;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled at 115200 baud (864 clocks per bit): table of
// frames, hand-written corner sequences and a random frame against a parity model.
module tb_uart_rx_oversampled;

    localparam int BIT        = 864;
    localparam int STOP_SHORT = 580;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic       parity_en, parity_odd, rx_serial, rx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_bussy, rx_tick, rx_error, rx_parity_err, rx_overrun;

    int n_vec   = 0;
    int n_bad   = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         pbit;
        logic [7:0] exp_byte;
        bit         exp_perr;
    } vec_t;

    vec_t vecs[3];

    uart_rx_oversampled dut (
        .clk           (clk),
        .rst           (rst),
        .baud_sel      (baud_sel),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .rx_serial     (rx_serial),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_bussy      (rx_bussy),
        .rx_tick       (rx_tick),
        .rx_error      (rx_error),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_error)   err_cnt <= err_cnt + 1;
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Parity error as seen on the wire: count ones over data plus parity bit.
    function automatic bit model_perr(input logic [7:0] d, input bit pen, input bit podd, input bit pbit);
        int ones;
        if (!pen) return 1'b0;
        ones = $countones(d) + int'(pbit);
        return podd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte"},  rx_byte, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_bussy"}, rx_bussy, 0);
        chk({tag, "_tick"},  rx_tick, 0);
        chk({tag, "_error"}, rx_error, 0);
        chk({tag, "_perr"},  rx_parity_err, 0);
        chk({tag, "_ovr"},   rx_overrun, 0);
    endtask

    // Drives one frame; line must be idle high with the receiver in IDLE on entry.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pbit,
                              input bit stopb, input int stop_len, input bit scramble);
        @(posedge clk); #1;
        parity_en  = pen;
        parity_odd = podd;
        rx_serial  = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("bussy_before_3cyc", rx_bussy, 0);
        @(posedge clk);
        #1 chk("bussy_at_3cyc", rx_bussy, 1);
        if (scramble) begin
            baud_sel   = 2'($urandom_range(0, 2));
            parity_en  = ~pen;
            parity_odd = ~podd;
        end
        repeat (BIT - 3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        if (pen) begin
            rx_serial = pbit;
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_serial = stopb;
        repeat (stop_len) @(posedge clk);
        #1;
        baud_sel = 2'd3;
    endtask

    // Raises rx_ready only in the cycle of the given tick of the next frame.
    task automatic ready_at_tick(input int tick_no);
        int guard = 0;
        int n     = 0;
        while (!rx_bussy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait_bussy", rx_bussy, 1);
        guard = 0;
        while (n < tick_no && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (rx_tick) n++;
        end
        chk("ready_tick_count", n, tick_no);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic consume();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        chk("valid_cleared", rx_valid, 0);
    endtask

    initial begin
        int e0, o0;
        logic [7:0] rd;
        bit rpen, rpodd, rpbit;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0};

        rst        = 1'b0;
        baud_sel   = 2'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_serial  = 1'b1;
        rx_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        rst = 1'b1;
        repeat (5) @(posedge clk);

        foreach (vecs[k]) begin
            e0 = err_cnt;
            send_frame(vecs[k].data, vecs[k].pen, vecs[k].podd, vecs[k].pbit, 1'b1, STOP_SHORT, 1'b0);
            chk($sformatf("vec%0d_valid", k), rx_valid, 1);
            chk($sformatf("vec%0d_byte", k), rx_byte, vecs[k].exp_byte);
            chk($sformatf("vec%0d_perr", k), rx_parity_err, vecs[k].exp_perr);
            chk($sformatf("vec%0d_no_error", k), err_cnt - e0, 0);
            consume();
        end

        // 0.3-bit glitch on idle line.
        e0 = err_cnt;
        o0 = ovr_cnt;
        @(posedge clk);
        #1 rx_serial = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("glitch_bussy_rise", rx_bussy, 1);
        repeat (BIT * 3 / 10 - 3) @(posedge clk);
        #1 rx_serial = 1'b1;
        repeat (700) @(posedge clk);
        #1 chk("glitch_bussy_back", rx_bussy, 0);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_no_error", err_cnt - e0, 0);
        chk("glitch_no_ovr", ovr_cnt - o0, 0);

        // Framing error: stop bit low, line low for two bit times.
        e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2 * BIT, 1'b0);
        rx_serial = 1'b1;
        chk("ferr_pulse_once", err_cnt - e0, 1);
        chk("ferr_valid", rx_valid, 0);
        repeat (100) @(posedge clk);
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, STOP_SHORT, 1'b0);
        chk("after_break_valid", rx_valid, 1);
        chk("after_break_byte", rx_byte, 8'h3C);
        chk("after_break_no_error", err_cnt - e0, 0);
        consume();

        // Back-to-back with consumer stalled, then accept in the completion cycle.
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, STOP_SHORT, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, STOP_SHORT, 1'b0);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_byte_held", rx_byte, 8'h11);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        o0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, STOP_SHORT, 1'b0);
            ready_at_tick(9 * 16 + 10);
        join
        chk("accept_valid", rx_valid, 1);
        chk("accept_byte", rx_byte, 8'h22);
        chk("accept_no_ovr", ovr_cnt - o0, 0);

        // Reset during data bit 4 of 0xFF, holding register still full.
        @(posedge clk);
        #1 rx_serial = 1'b0;
        repeat (BIT) @(posedge clk);
        #1 rx_serial = 1'b1;
        repeat (4 * BIT + BIT / 2) @(posedge clk);
        #1 chk("pre_reset_bussy", rx_bussy, 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("midframe_reset");
        rst = 1'b1;
        repeat (50) @(posedge clk);
        e0 = err_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, STOP_SHORT, 1'b0);
        chk("post_reset_valid", rx_valid, 1);
        chk("post_reset_byte", rx_byte, 8'h81);
        chk("post_reset_no_error", err_cnt - e0, 0);
        consume();

        // Random frame; config inputs are scrambled after the start edge.
        repeat ($urandom_range(5, 60)) @(posedge clk);
        rd    = 8'($urandom);
        rpen  = 1'($urandom);
        rpodd = 1'($urandom);
        rpbit = 1'($urandom);
        e0    = err_cnt;
        send_frame(rd, rpen, rpodd, rpbit, 1'b1, STOP_SHORT, 1'b1);
        chk("rand_valid", rx_valid, 1);
        chk("rand_byte", rx_byte, rd);
        chk("rand_perr", rx_parity_err, model_perr(rd, rpen, rpodd, rpbit));
        chk("rand_no_error", err_cnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
